// File: rtl/vga_pkg.sv
// Shared text-overlay geometry and reveal FSM types.
// Imported by the character source and its font ROM.
package vga_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CHAR_H = 16;
  localparam int unsigned TEXT_COLS = 16;
  localparam int unsigned TEXT_ROWS = 16;
  localparam int unsigned TEXT_CELLS = TEXT_COLS * TEXT_ROWS;

  localparam logic [6:0] DEFAULT_BLANK_CODE = 7'h20;

  typedef enum logic [1:0] {
    IDLE,
    REVEAL,
    DONE
  } reveal_state_e;

endpackage

// File: rtl/font_rom_8x16.sv
// 128 x 16 x 8 glyph ROM, one registered read per cycle.
// Printable codes without a dedicated glyph draw a hollow box.
module font_rom_8x16
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic [10:0]       addr,
  output logic [CHAR_W-1:0] data
);

  logic [6:0]        code;
  logic [3:0]        row;
  logic [CHAR_W-1:0] data_d;
  logic [CHAR_W-1:0] data_q;

  assign code = addr[10:4];
  assign row  = addr[3:0];

  always_comb begin
    data_d = '0;
    case (code)
      7'h41: begin
        case (row)
          4'd2:    data_d = 8'h10;
          4'd3:    data_d = 8'h38;
          4'd4:    data_d = 8'h6C;
          4'd5:    data_d = 8'hC6;
          4'd6:    data_d = 8'hC6;
          4'd7:    data_d = 8'hFE;
          4'd8:    data_d = 8'hC6;
          4'd9:    data_d = 8'hC6;
          4'd10:   data_d = 8'hC6;
          4'd11:   data_d = 8'hC6;
          default: data_d = 8'h00;
        endcase
      end
      7'h42: begin
        case (row)
          4'd2:    data_d = 8'hFC;
          4'd3:    data_d = 8'h66;
          4'd4:    data_d = 8'h66;
          4'd5:    data_d = 8'h66;
          4'd6:    data_d = 8'h7C;
          4'd7:    data_d = 8'h66;
          4'd8:    data_d = 8'h66;
          4'd9:    data_d = 8'h66;
          4'd10:   data_d = 8'h66;
          4'd11:   data_d = 8'hFC;
          default: data_d = 8'h00;
        endcase
      end
      default: begin
        // controls, space and DEL stay dark
        if (code > 7'h20 && code != 7'h7F) begin
          unique case (1'b1)
            (row == 4'd2 || row == 4'd13): data_d = 8'h7E;
            (row > 4'd2 && row < 4'd13):   data_d = 8'h42;
            default:                       data_d = 8'h00;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/text_box_char_source.sv
// Text-box character source: 16x16 text RAM, font lookup and
// a frame-paced typewriter reveal of the first TEXT_LEN cells.
module text_box_char_source
  import vga_pkg::*;
#(
  parameter int unsigned REVEAL_FRAMES = 4,
  parameter int unsigned TEXT_LEN      = 80,
  parameter logic [6:0]  BLANK_CODE    = DEFAULT_BLANK_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync_in,
  input  logic [7:0]        char_xy,
  input  logic [3:0]        char_line,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [6:0]        wr_data,
  input  logic              restart,
  output logic [CHAR_W-1:0] char_pixels,
  output logic [8:0]        reveal_count,
  output logic              reveal_done
);

  localparam logic [7:0] FRM_LAST = 8'(REVEAL_FRAMES - 1);
  localparam logic [8:0] LEN      = 9'(TEXT_LEN);

  logic [6:0] text_ram [TEXT_CELLS] = '{default: BLANK_CODE};

  reveal_state_e state_q, state_d;
  logic [7:0]    frm_q, frm_d;
  logic [8:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          vsync_prev_q;
  logic          frame_edge;

  logic [7:0]    xy_q;
  logic [3:0]    line_q;
  logic [6:0]    code_q;
  logic          pix_vld_q;
  logic [6:0]    show_code;
  logic [10:0]   rom_addr;
  logic [7:0]    rom_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      text_ram[wr_addr] <= wr_data;
    end
  end

  assign frame_edge = vsync_in & ~vsync_prev_q;

  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = IDLE;
      frm_d   = '0;
      cnt_d   = '0;
    end else if (frame_edge) begin
      unique case (state_q)
        IDLE: state_d = REVEAL;
        REVEAL: begin
          if (frm_q == FRM_LAST) begin
            frm_d = '0;
            cnt_d = cnt_q + 9'd1;
            if (cnt_q + 9'd1 == LEN) begin
              state_d = DONE;
            end
          end else begin
            frm_d = frm_q + 8'd1;
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      frm_q        <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      vsync_prev_q <= 1'b0;
      xy_q         <= '0;
      line_q       <= '0;
      code_q       <= '0;
      pix_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frm_q        <= frm_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      vsync_prev_q <= vsync_in;
      xy_q         <= char_xy;
      line_q       <= char_line;
      code_q       <= text_ram[char_xy];
      pix_vld_q    <= 1'b1;
    end
  end

  // unrevealed cells, including everything past TEXT_LEN, read blank
  assign show_code = ({1'b0, xy_q} >= cnt_q) ? BLANK_CODE : code_q;
  assign rom_addr  = {show_code, line_q};

  font_rom_8x16 u_font (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  assign char_pixels  = pix_vld_q ? rom_data : '0;
  assign reveal_count = cnt_q;
  assign reveal_done  = done_q;

endmodule

// File: tb/tb_text_box_char_source.sv
// Bench: two instances (reveal every frame / every 4 frames)
// checked each cycle against a behavioural model.
module tb_text_box_char_source;

  localparam int LEN = 80;
  localparam logic [6:0] BLANK = 7'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [6:0] wr_data;
  logic       restart;

  logic [7:0] pix1, pix4;
  logic [8:0] cnt1, cnt4;
  logic       done1, done4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] a_rows [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6,
                              8'hC6, 8'hFE, 8'hC6, 8'hC6, 8'hC6, 8'hC6,
                              8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] b_rows [16] = '{8'h00, 8'h00, 8'hFC, 8'h66, 8'h66, 8'h66,
                              8'h7C, 8'h66, 8'h66, 8'h66, 8'h66, 8'hFC,
                              8'h00, 8'h00, 8'h00, 8'h00};

  // model state
  logic [6:0] m_ram [256];
  logic       m_vprev;
  logic [7:0] s1_xy;
  logic [3:0] s1_line;
  logic [6:0] s1_code;
  int         m_rf  [2] = '{1, 4};
  int         m_cnt [2];
  int         m_frm [2];
  bit         m_run [2];
  logic [7:0] m_pix [2];

  always #5 clk = ~clk;

  text_box_char_source #(
    .REVEAL_FRAMES (1),
    .TEXT_LEN      (LEN),
    .BLANK_CODE    (BLANK)
  ) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .char_xy      (char_xy),
    .char_line    (char_line),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .restart      (restart),
    .char_pixels  (pix1),
    .reveal_count (cnt1),
    .reveal_done  (done1)
  );

  text_box_char_source #(
    .REVEAL_FRAMES (4),
    .TEXT_LEN      (LEN),
    .BLANK_CODE    (BLANK)
  ) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .char_xy      (char_xy),
    .char_line    (char_line),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .restart      (restart),
    .char_pixels  (pix4),
    .reveal_count (cnt4),
    .reveal_done  (done4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [6:0] c,
                                       input logic [3:0] r);
    if (c == 7'h41) return a_rows[r];
    if (c == 7'h42) return b_rows[r];
    if (c <= 7'h20 || c == 7'h7F) return 8'h00;
    if (r == 4'd2 || r == 4'd13) return 8'h7E;
    if (r > 4'd2 && r < 4'd13) return 8'h42;
    return 8'h00;
  endfunction

  task automatic model_edge();
    logic fe;
    logic [6:0] shown;
    fe = vsync_in & ~m_vprev;
    for (int d = 0; d < 2; d++) begin
      shown = (int'(s1_xy) >= m_cnt[d]) ? BLANK : s1_code;
      m_pix[d] = rst ? 8'h00 : glyph(shown, s1_line);
    end
    if (rst) begin
      s1_xy = '0; s1_line = '0; s1_code = '0;
    end else begin
      s1_xy = char_xy; s1_line = char_line; s1_code = m_ram[char_xy];
    end
    if (wr_en) m_ram[wr_addr] = wr_data;
    for (int d = 0; d < 2; d++) begin
      if (rst || restart) begin
        m_cnt[d] = 0; m_frm[d] = 0; m_run[d] = 0;
      end else if (fe) begin
        if (!m_run[d]) m_run[d] = 1;
        else if (m_cnt[d] < LEN) begin
          m_frm[d]++;
          if (m_frm[d] == m_rf[d]) begin
            m_frm[d] = 0;
            m_cnt[d]++;
          end
        end
      end
    end
    m_vprev = rst ? 1'b0 : vsync_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pix1", pix1, m_pix[0]);
    check("cnt1", cnt1, m_cnt[0]);
    check("done1", done1, m_cnt[0] == LEN);
    check("pix4", pix4, m_pix[1]);
    check("cnt4", cnt4, m_cnt[1]);
    check("done4", done4, m_cnt[1] == LEN);
  endtask

  task automatic frame();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  task automatic rand_io();
    char_xy   = 8'($urandom);
    char_line = 4'($urandom);
    wr_en     = ($urandom_range(0, 3) == 0);
    wr_addr   = 8'($urandom);
    wr_data   = 7'($urandom);
    if (wr_addr == 8'h00 || wr_addr == 8'h10) wr_en = 1'b0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) m_ram[i] = BLANK;
    m_vprev = 0; s1_xy = '0; s1_line = '0; s1_code = '0;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_frm[d] = 0; m_run[d] = 0; m_pix[d] = '0;
    end
    rst = 1'b1; vsync_in = 1'b0; restart = 1'b0;
    char_xy = 8'h00; char_line = 4'd5;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();
    check("idle_pix", pix1, 8'h00);
    check("idle_cnt", cnt1, 0);
    check("idle_done", done1, 0);

    wr_en = 1'b1; wr_addr = 8'h00; wr_data = 7'h41;
    step();
    wr_en = 1'b0;
    frame();
    frame();
    check("two_edges_cnt1", cnt1, 1);
    for (int l = 0; l < 16; l++) begin
      char_xy = 8'h00; char_line = 4'(l);
      step();
    end
    char_xy = 8'h01; char_line = 4'd7;
    step();
    step();
    check("a_row15", pix1, a_rows[15]);
    step();
    check("unrevealed", pix1, 8'h00);

    for (int f = 0; f < 340; f++) begin
      rand_io();
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        rand_io();
        step();
      end
    end
    wr_en = 1'b0;
    check("full_cnt4", cnt4, 80);
    check("full_done4", done4, 1);
    check("full_cnt1", cnt1, 80);

    vsync_in = 1'b1; restart = 1'b1;
    step();
    vsync_in = 1'b0; restart = 1'b0;
    check("restart_cnt", cnt4, 0);
    check("restart_done", done4, 0);
    step();
    frame();
    check("enter_reveal", cnt1, 0);
    frame();
    check("first_after", cnt1, 1);

    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 7'h41;
    step();
    wr_en = 1'b0;
    repeat (20) frame();
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 7'h42;
    char_xy = 8'h10; char_line = 4'd3;
    step();
    wr_en = 1'b0;
    step();
    check("rw_old", pix1, a_rows[3]);
    step();
    check("rw_new", pix1, b_rows[3]);

    guard = 0;
    while (cnt1 != 9'd37 && guard < 60) begin
      frame();
      guard++;
    end
    check("reach37", cnt1, 37);
    rst = 1'b1;
    step();
    check("rst_cnt", cnt1, 0);
    check("rst_pix", pix1, 8'h00);
    rst = 1'b0;
    frame();
    frame();
    char_xy = 8'h00; char_line = 4'd4;
    step();
    step();
    check("ram_kept", pix1, a_rows[4]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
